// File: rtl/mant_mul24_seq.sv
// mant_mul24_seq -- multi-cycle unsigned mantissa multiplier (W x W -> 2W).
//
// Operands are split into 8-bit slices. One slice pair goes through a single
// combinational 8x8 array multiplier (mul_8array) each cycle, and the 16-bit
// partial product is shifted into place and added to a 2W-bit accumulator.
// SLICES*SLICES cycles later the accumulator holds a*b and is offered
// downstream.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready is high only in IDLE. out_valid is
// high only in DONE. While out_valid=1 and out_ready=0, p holds steady.
//
// Parameters:
//   SLICES    number of 8-bit slices per operand (W = 8*SLICES)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (a, b captured on transfer)
//   a, b              W-bit unsigned operands
//   out_valid/out_ready result handshake
//   p                 2W-bit product (equals the accumulator; qualify with out_valid)
//   busy              high while slices are being multiplied
//
// Optional build macro: MANT_MUL_ZERO_SKIP_EN
//   When defined, a zero operand bypasses the multiply loop and the zero
//   result is offered one cycle after acceptance. busy stays low on that path.

module mul_8array (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    // Shift-and-add array: row i contributes a<<i when b[i] is set.
    logic [15:0] row [8];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            row[i] = b[i] ? (16'(a) << i) : 16'd0;
        end
    end

    always_comb begin
        p = 16'd0;
        for (int i = 0; i < 8; i++) begin
            p = p + row[i];
        end
    end
endmodule

module mant_mul24_seq #(
    parameter int SLICES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*SLICES-1:0]     a,
    input  logic [8*SLICES-1:0]     b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [16*SLICES-1:0]    p,
    output logic                    busy
);
    localparam int W     = 8 * SLICES;
    localparam int PW    = 2 * W;
    localparam int NPROD = SLICES * SLICES;
    localparam int KW    = (NPROD > 1) ? $clog2(NPROD) : 1;

    // ST_ZSKIP is only entered in the zero-skip build: it spaces the zero
    // result one cycle after acceptance without raising busy.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ZSKIP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [KW-1:0]   k_q, k_d;

    // Slice selection: k walks the a-slices fastest, then the b-slices.
    logic [KW-1:0]   a_idx;
    logic [KW-1:0]   b_idx;
    logic [KW:0]     idx_sum;
    logic [7:0]      a_slice;
    logic [7:0]      b_slice;
    logic [15:0]     slice_prod;
    logic [PW-1:0]   partial;
    logic            last_k;

    assign a_idx   = k_q % KW'(SLICES);
    assign b_idx   = k_q / KW'(SLICES);
    assign idx_sum = {1'b0, a_idx} + {1'b0, b_idx};
    assign a_slice = a_q[8*a_idx +: 8];
    assign b_slice = b_q[8*b_idx +: 8];
    assign last_k  = (k_q == KW'(NPROD - 1));

    mul_8array u_mul (
        .a (a_slice),
        .b (b_slice),
        .p (slice_prod)
    );

    // Weight of slice pair (i, j) is 2^(8*(i+j)).
    assign partial = {{(PW-16){1'b0}}, slice_prod} << {idx_sum, 3'b000};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        k_d     = k_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d   = a;
                    b_d   = b;
                    acc_d = '0;
                    k_d   = '0;
`ifdef MANT_MUL_ZERO_SKIP_EN
                    if ((a == '0) || (b == '0)) begin
                        state_d = ST_ZSKIP;
                    end else begin
                        state_d = ST_MUL;
                    end
`else
                    state_d = ST_MUL;
`endif
                end
            end
            ST_MUL: begin
                acc_d = acc_q + partial;
                if (last_k) begin
                    k_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_ZSKIP: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
        end
    end

    // All handshake outputs decode directly from the registered state.
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_MUL);
    assign out_valid = (state_q == ST_DONE);
    assign p         = acc_q;
endmodule

// File: tb/tb_mant_mul24_seq.sv
// Directed bench for mant_mul24_seq (SLICES=3, W=24).
module tb_mant_mul24_seq;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] a;
    logic [23:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] p;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

`ifdef MANT_MUL_ZERO_SKIP_EN
    localparam int ZERO_LAT  = 1;
    localparam int ZERO_BUSY = 0;
`else
    localparam int ZERO_LAT  = 9;
    localparam int ZERO_BUSY = 9;
`endif

    mant_mul24_seq #(.SLICES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands in IDLE; returns after the acceptance edge E0.
    task automatic send_op(input logic [23:0] av, input logic [23:0] bv);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        // Scramble the inputs: they must not affect the operation in flight.
        a = 24'h5A5A5A;
        b = 24'hC3C3C3;
    endtask

    // Called right after E0; counts cycles to out_valid and busy samples.
    task automatic wait_result(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_n++;
            step();
            lat++;
        end
        if (!out_valid) check_eq("out_valid timeout", 64'd0, 64'd1);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
        check_eq({tag, " in_ready back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [23:0] av, input logic [23:0] bv,
                          input logic [47:0] exp_p, input int exp_lat, input int exp_busy);
        int lat;
        int busy_n;
        send_op(av, bv);
        wait_result(lat, busy_n);
        check_eq({tag, " p"}, 64'(p), 64'(exp_p));
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, " busy cycles"}, 64'(busy_n), 64'(exp_busy));
        consume(tag);
    endtask

    // ---------------- stimulus ----------------
    logic [23:0] bb_a [4];
    logic [23:0] bb_b [4];
    logic [47:0] bb_p [4];

    initial begin
        int lat;
        int busy_n;
        int start_cyc;
        int prev_start;
        logic [47:0] held_p;

        rst       = 1'b1;
        in_valid  = 1'b1;   // reset must win over in_valid
        out_ready = 1'b0;
        a         = 24'h000001;
        b         = 24'h000001;
        step();
        step();
        check_eq("reset in_ready", 64'(in_ready), 64'd1);
        check_eq("reset out_valid", 64'(out_valid), 64'd0);
        check_eq("reset busy", 64'(busy), 64'd0);
        check_eq("reset p", 64'(p), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        check_eq("idle after reset busy", 64'(busy), 64'd0);

        // 1..3: main function
        run_op("max",     24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 9, 9);
        run_op("msb",     24'h800000, 24'h800000, 48'h400000000000, 9, 9);
        run_op("by_one",  24'h123456, 24'h000001, 48'h000000123456, 9, 9);
        run_op("mixed",   24'h00FF00, 24'h0000FF, 48'h0000FE0100,   9, 9);
        run_op("zero_a",  24'h000000, 24'hABCDEF, 48'h0, ZERO_LAT, ZERO_BUSY);

        // 4: backpressure
        send_op(24'h000007, 24'h000009);
        wait_result(lat, busy_n);
        check_eq("bp p", 64'(p), 64'd63);
        held_p = p;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                a        = 24'h000001;
                b        = 24'h000001;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            check_eq("bp p stable", 64'(p), 64'(held_p));
            check_eq("bp out_valid held", 64'(out_valid), 64'd1);
            check_eq("bp in_ready low", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        consume("bp");
        check_eq("bp not captured busy", 64'(busy), 64'd0);
        check_eq("bp not captured p", 64'(p), 64'd63);

        // 5: reset during the 4th MUL cycle
        send_op(24'hFFFFFF, 24'h000002);   // now in MUL cycle 1
        step();
        step();
        step();                              // MUL cycle 4
        check_eq("pre-abort busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("abort in_ready", 64'(in_ready), 64'd1);
        check_eq("abort out_valid", 64'(out_valid), 64'd0);
        check_eq("abort p", 64'(p), 64'd0);
        check_eq("abort busy", 64'(busy), 64'd0);
        run_op("after_abort", 24'h000003, 24'h000005, 48'h00000000000F, 9, 9);

        // 6: back-to-back with in_valid and out_ready tied high
        bb_a[0] = 24'h000001; bb_b[0] = 24'hFFFFFF; bb_p[0] = 48'h000000FFFFFF;
        bb_a[1] = 24'h00FF00; bb_b[1] = 24'h000100; bb_p[1] = 48'h000000FF0000;
        bb_a[2] = 24'hAAAAAA; bb_b[2] = 24'h000003; bb_p[2] = 48'h000001FFFFFE;
        bb_a[3] = 24'h100000; bb_b[3] = 24'h100000; bb_p[3] = 48'h010000000000;
        out_ready  = 1'b1;
        prev_start = -1;
        a          = bb_a[0];
        b          = bb_b[0];
        in_valid   = 1'b1;
        for (int n = 0; n < 4; n++) begin
            lat = 0;
            while (!busy && lat < 20) begin
                step();
                lat++;
            end
            if (!busy) check_eq("b2b start timeout", 64'd0, 64'd1);
            start_cyc = cyc;
            if (prev_start >= 0)
                check_eq("b2b spacing", 64'(start_cyc - prev_start), 64'd11);
            prev_start = start_cyc;
            a = 24'h0F0F0F;   // junk while busy
            b = 24'hF0F0F0;
            wait_result(lat, busy_n);
            check_eq("b2b p", 64'(p), 64'(bb_p[n]));
            if (n < 3) begin
                a = bb_a[n+1];
                b = bb_b[n+1];
            end else begin
                in_valid = 1'b0;
            end
            step();
            check_eq("b2b out_valid 1 cycle", 64'(out_valid), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mant_mul24_seq.md
Name: mant_mul24_seq

Overview:
Multi-cycle 24x24 unsigned mantissa multiplier for the FPU multiply path. It sits directly upstream of the 8x8 array multiplier, mul_8array, and instantiates exactly one copy of it. On each cycle it feeds one 8-bit slice pair into the array and accumulates the returned 16-bit product into a 48-bit result. The result goes downstream to the normalise/round stage through a valid/ready handshake.

Parameters:
SLICES, 3, number of 8-bit slices per operand; operand width W = 8*SLICES (24 for single precision).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands a and b are valid.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  W  multiplicand mantissa, unsigned, hidden bit included.
b  input  W  multiplier mantissa, unsigned.
out_valid  output  1  p holds the final product.
out_ready  input  1  downstream consumes p.
p  output  2W  product a*b, unsigned.
busy  output  1  high in MUL state.

Behaviour:
- One clock. Reset is synchronous and active-high. Ports are clk and rst.
- Reset values: state=IDLE; in_ready=1; out_valid=0; busy=0; p=0; slice counter k=0.
- FSM states:
  - IDLE: in_ready=1. When in_valid&in_ready: latch a and b into internal registers, clear the accumulator, set k=0, go to MUL.
  - MUL: busy=1, in_ready=0.
    - Each cycle, feed mul_8array with a_reg[8*(k%SLICES)+:8] and b_reg[8*(k/SLICES)+:8].
    - Add the 16-bit product, zero-extended and shifted left by 8*((k%SLICES)+(k/SLICES)), into the 2W-bit accumulator. Then k=k+1.
    - After the edge that accumulates k=SLICES*SLICES-1, go to DONE.
  - DONE: out_valid=1, p=accumulator. Stay in DONE while out_ready=0. On out_ready=1, go to IDLE with out_valid=0 on the next cycle.
- Latency: with acceptance at edge E0, MUL occupies SLICES^2 cycles (9 by default), and out_valid first rises after edge E9. Total occupancy is 11 cycles at minimum.
- No overlap: in_ready=0 in MUL and DONE. in_valid is ignored in those states, and operands presented then are not captured.
- Arithmetic: the accumulator is exactly 2W bits. The true product always fits in 2W bits, so no overflow handling exists. The adder is a plain 2W-bit add of accumulator + shifted partial.
- p is stable while out_valid=1 and out_ready=0 (backpressure). Changes to a or b after acceptance have no effect.
- p retains its last value in IDLE. Downstream must qualify p with out_valid.
- Reset mid-operation (MUL or DONE): abort, return to IDLE with all reset values. The partial result is discarded and no out_valid pulse is produced.
- in_valid and rst high together: reset wins and nothing is accepted.
- mul_8array is purely combinational. The accumulator register is the only pipeline register on the multiply path.

Optional Feature:
MANT_MUL_ZERO_SKIP_EN:
- Defined: at acceptance, if a==0 or b==0, skip MUL and go straight from IDLE to DONE with accumulator=0. out_valid rises after E1.
- Not defined: zero operands take the normal SLICES^2-cycle path; the result is still 0.
- All other behaviour is identical in both builds.

Test Plan:
1. a=0xFFFFFF, b=0xFFFFFF -> p=0xFFFFFE000001; out_valid first seen 9 cycles after the acceptance edge; busy high for exactly 9 cycles.
2. a=0x800000, b=0x800000 -> p=0x400000000000. Also a=0x123456, b=0x000001 -> p=0x000000123456.
3. a=0, b=0xABCDEF -> p=0. Latency is 9 cycles without MANT_MUL_ZERO_SKIP_EN and 1 cycle with it; busy never rises in the skip build.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid. p, out_valid=1 and in_ready=0 stay stable. An in_valid pulse with a=1, b=1 during this window is not captured. After out_ready=1, in_ready=1 on the next cycle.
5. Reset at the 4th MUL cycle of a=0xFFFFFF, b=0x000002 -> next cycle state is IDLE, out_valid=0, p=0, in_ready=1. A following op a=0x000003, b=0x000005 gives p=0x00000000000F.
6. Back-to-back: out_ready tied 1, in_valid tied 1 with a stream of 4 random operand pairs -> each p matches the reference model a*b, each out_valid lasts 1 cycle, and operations start 11 cycles apart.
